dma_controller: RTL

Bus-master DMA engine that services the CPU's DMA command and shares the data-memory bus with the CPU through the BR/BG handshake. It decodes the 16-bit command into a base address and a word count. It then requests the bus, writes the device buffer to data memory one 64-bit line at a time, releases the bus, and pulses a completion signal (DMA_end) back to the CPU.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_line_timer.sv | 30 +++
 rtl/dma_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: state encodings, command field positions,
// and the helper that turns a word count into a line count.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  localparam int LEN_MSB        = 15;
  localparam int LEN_LSB        = 12;
  localparam int BASE_MSB       = 11;
  localparam int BASE_LSB       = 0;
  localparam int WORDS_PER_LINE = 4;

  // ceil(len / 4): a partial final line still costs a full line write
  function automatic logic [2:0] len_to_lines(input logic [3:0] len);
    logic [4:0] sum;
    sum = {1'b0, len} + 5'd3;
    return sum[4:2];
  endfunction

endpackage

// File: rtl/dma_line_timer.sv
// Per-line write latency timer: loads MEM_LAT-1 on clear, counts down while enabled,
// and flags the final cycle of the line when it reaches zero.
module dma_line_timer #(
  parameter int MEM_LAT = 4
) (
  input  logic Clk,
  input  logic Reset_N,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine: accepts a command, requests the data bus via BR/BG, writes the
// device buffer to memory one line per MEM_LAT cycles, then pulses DMA_end.
//
// state | meaning
// IDLE  | waiting for cmd_valid
// REQ   | BR high, waiting for BG (also re-entered when BG is withdrawn mid-line)
// XFER  | driving the bus for the current line
// DONE  | one-cycle DMA_end pulse, bus released
module dma_controller
  import dma_pkg::*;
#(
  parameter int MEM_LAT   = 4,
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] DMA_command,
  input  logic                 BG,
  output logic                 BR,
  output logic                 DMA_end,
  output logic                 busy,
  output logic [1:0]           dev_index,
  input  logic [LINE_SIZE-1:0] dev_data,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [LINE_SIZE-1:0] d_data
);

  dma_state_t           state, state_nx;
  logic [WORD_SIZE-1:0] base;
  logic [1:0]           last_idx;
  logic [3:0]           cmd_len;
  logic [2:0]           cmd_lines;
  logic [WORD_SIZE-1:0] line_addr;
  logic                 line_last, timer_clr, timer_en, line_adv, drive;

  assign cmd_len   = DMA_command[LEN_MSB:LEN_LSB];
  assign cmd_lines = len_to_lines(cmd_len);

  dma_line_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .clr     (timer_clr),
    .en      (timer_en),
    .last    (line_last)
  );

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      base      <= '0;
      last_idx  <= '0;
      dev_index <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        base     <= WORD_SIZE'(DMA_command[BASE_MSB:BASE_LSB]);
        last_idx <= 2'(cmd_lines - 3'd1);
      end
      if (line_adv) begin
        dev_index <= dev_index + 1'b1;
      end else if (state == DONE) begin
        dev_index <= '0;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    line_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nx = (cmd_len != 4'd0) ? REQ : DONE;
      end
      REQ: begin
        // hold the counter loaded so every (re)grant starts a full line
        timer_clr = 1'b1;
        if (BG) state_nx = XFER;
      end
      XFER: begin
        if (!BG) begin
          state_nx = REQ;
        end else if (line_last) begin
          if (dev_index == last_idx) begin
            state_nx = DONE;
          end else begin
            line_adv  = 1'b1;
            timer_clr = 1'b1;
          end
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BR      = (state == REQ) || (state == XFER);
  assign DMA_end = (state == DONE);
  assign busy    = (state != IDLE);

  // gated on BG directly so the bus is released in the same cycle the grant drops
  assign drive     = (state == XFER) && BG;
  assign line_addr = base + (WORD_SIZE'(dev_index) << $clog2(WORDS_PER_LINE));

  assign d_writeM  = drive ? 1'b1      : 1'bz;
  assign d_address = drive ? line_addr : 'z;
  assign d_data    = drive ? dev_data  : 'z;

endmodule
